// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial adder/subtractor. A single full-adder/full-subtractor slice is
// reused once per clock, walking the latched WIDTH-bit operands LSB-first.
// The carry (add) or borrow (subtract) is held in a register between slices.
// A start/done handshake frames each operation. One operation takes WIDTH+1
// cycles: the accept edge, then one edge per bit.
//
// Parameters
//   WIDTH   operand/result width in bits (WIDTH >= 2)
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   start   request, sampled only while idle
//   mode    0 = add (a + b), 1 = subtract (a - b); latched at accept
//   a, b    operands; latched at accept
//   busy    high while an operation is in progress
//   done    one-cycle pulse; result/cout/ovf are valid
//   result  sum or difference modulo 2^WIDTH
//   cout    add: carry out of MSB; subtract: borrow out of MSB
//   ovf     two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    // Bit counter is just wide enough to index WIDTH bits.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             mode_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;

    // FSM decode strobes
    logic accept;   // start taken in IDLE this edge
    logic step;     // one bit slice is processed this edge
    logic finish;   // the MSB slice is processed this edge

    // Bit-slice datapath
    logic [WIDTH-1:0] bit_sel;   // one-hot decode of cnt_q
    logic             a_bit, b_bit;
    logic             sum_bit;
    logic             c_next;
    logic             last_bit;

    // -------------------------------------------------------------------------
    // One-hot bit select. Operand bits are picked with an AND/OR reduction
    // instead of a variable index, and the same decode steers the result
    // write enable of each bit.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bit_sel[gi] = (cnt_q == CW'(gi));

            // Result bits are cleared on accept and written once, when their
            // slice is processed; otherwise they hold.
            assign result_d[gi] = accept                ? 1'b0    :
                                  (step && bit_sel[gi]) ? sum_bit :
                                                          result_q[gi];
        end
    endgenerate

    assign a_bit    = |(a_q & bit_sel);
    assign b_bit    = |(b_q & bit_sel);
    assign last_bit = (cnt_q == LAST_IDX);

    // Full adder / full subtractor slice. The sum/difference bit is the same
    // XOR for both; only the carry vs. borrow generation differs.
    always_comb begin
        sum_bit = a_bit ^ b_bit ^ c_q;
        if (mode_q) begin
            c_next = (~a_bit & b_bit) | (c_q & ~(a_bit ^ b_bit));
        end else begin
            c_next = (a_bit & b_bit) | (c_q & (a_bit ^ b_bit));
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and strobes
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // start is deliberately ignored here
                step = 1'b1;
                if (last_bit) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
        end
    end

    // -------------------------------------------------------------------------
    // Operand latch, carry/borrow register and bit counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            c_q    <= 1'b0;
            cnt_q  <= '0;
        end else if (step) begin
            c_q <= c_next;
            // Wrap to 0 after the MSB so the counter never exceeds WIDTH-1.
            cnt_q <= last_bit ? '0 : cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Result and flags. cout/ovf change only when the MSB slice completes and
    // hold until the next completed operation.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            if (finish) begin
                cout_q <= c_next;
                // Signed overflow: carry into the MSB differs from carry out.
                ovf_q  <= c_q ^ c_next;
            end
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//
// Self-checking bench for serial_addsub. Three instances (WIDTH = 8, 2, 13)
// share operand/mode/reset drives; each has its own start. Directed vectors
// for WIDTH=8 come from a table; reset, handshake and parametrised random
// runs are hand-written sequences. Expected values are computed here.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [12:0] a_p, b_p;
    logic        mode_p;
    logic        start8, start2, start13;

    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  res8;
    logic        busy2, done2, cout2, ovf2;
    logic [1:0]  res2;
    logic        busy13, done13, cout13, ovf13;
    logic [12:0] res13;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode_p),
        .a(a_p[7:0]), .b(b_p[7:0]),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
    );

    serial_addsub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode_p),
        .a(a_p[1:0]), .b(b_p[1:0]),
        .busy(busy2), .done(done2), .result(res2), .cout(cout2), .ovf(ovf2)
    );

    serial_addsub #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .mode(mode_p),
        .a(a_p), .b(b_p),
        .busy(busy13), .done(done13), .result(res13), .cout(cout13), .ovf(ovf13)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic sel_done(input int w);
        return (w == 2) ? done2 : (w == 13) ? done13 : done8;
    endfunction

    function automatic logic sel_busy(input int w);
        return (w == 2) ? busy2 : (w == 13) ? busy13 : busy8;
    endfunction

    // Runs one operation on the chosen instance. lat = edges from the accept
    // edge until done is seen; busy_cnt = sampled cycles with busy high;
    // done_after = done one cycle after it was first seen.
    task automatic run_op(input int w, input logic [12:0] av, input logic [12:0] bv,
                          input logic m, output logic [12:0] r, output logic co,
                          output logic ov, output int lat, output int busy_cnt,
                          output logic done_after);
        @(negedge clk);
        a_p = av; b_p = bv; mode_p = m;
        if (w == 2) start2 = 1'b1; else if (w == 13) start13 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0; start8 = 1'b0; start13 = 1'b0;
        lat = -1; busy_cnt = 0;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (sel_done(w)) begin
                lat = n;
                break;
            end
            if (sel_busy(w)) busy_cnt++;
        end
        if (w == 2) begin
            r = {11'b0, res2}; co = cout2; ov = ovf2;
        end else if (w == 13) begin
            r = res13; co = cout13; ov = ovf13;
        end else begin
            r = {5'b0, res8}; co = cout8; ov = ovf8;
        end
        @(posedge clk); #1;
        done_after = sel_done(w);
        $display("op w=%0d %s a=%0h b=%0h -> result=%0h cout=%0b ovf=%0b lat=%0d",
                 w, m ? "sub" : "add", av, bv, r, co, ov, lat);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        logic [7:0] r;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vt[11];

    logic [12:0] r;
    logic        co, ov, da;
    int          lat, bc;

    initial begin
        // a, b, mode, result, cout, ovf -- hand-computed
        vt[0]  = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
        vt[1]  = '{8'd5,   8'd9,   1'b1, 8'hFC,  1'b1, 1'b0};
        vt[2]  = '{8'h80,  8'h01,  1'b1, 8'h7F,  1'b0, 1'b1};
        vt[3]  = '{8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1};
        vt[4]  = '{8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0};
        vt[5]  = '{8'h00,  8'h00,  1'b0, 8'h00,  1'b0, 1'b0};
        vt[6]  = '{8'h00,  8'h00,  1'b1, 8'h00,  1'b0, 1'b0};
        vt[7]  = '{8'h00,  8'h80,  1'b1, 8'h80,  1'b1, 1'b1};
        vt[8]  = '{8'h7F,  8'hFF,  1'b1, 8'h80,  1'b1, 1'b1};
        vt[9]  = '{8'h3C,  8'h0F,  1'b1, 8'h2D,  1'b0, 1'b0};
        vt[10] = '{8'h80,  8'h80,  1'b0, 8'h00,  1'b1, 1'b1};

        a_p = '0; b_p = '0; mode_p = 1'b0;
        start2 = 1'b0; start8 = 1'b0; start13 = 1'b0;

        // ---------------- reset state, reset dominates start ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        rst = 1'b0;
        chk("rst_busy",   busy8, 0);
        chk("rst_done",   done8, 0);
        chk("rst_result", res8,  0);
        chk("rst_cout",   cout8, 0);
        chk("rst_ovf",    ovf8,  0);
        @(posedge clk); #1;
        chk("rst_dominates_start", busy8, 0);

        // ---------------- table-driven WIDTH=8 vectors ----------------
        foreach (vt[i]) begin
            run_op(8, {5'b0, vt[i].a}, {5'b0, vt[i].b}, vt[i].m, r, co, ov, lat, bc, da);
            chk($sformatf("v%0d_result", i), r,   vt[i].r);
            chk($sformatf("v%0d_cout", i),   co,  vt[i].co);
            chk($sformatf("v%0d_ovf", i),    ov,  vt[i].ov);
            chk($sformatf("v%0d_latency", i), lat, 8);
            chk($sformatf("v%0d_busy_cycles", i), bc, 8);
            chk($sformatf("v%0d_done_pulse", i), da, 0);
        end

        // ---------------- reset mid-operation ----------------
        run_op(8, 13'h80, 13'h80, 1'b0, r, co, ov, lat, bc, da);  // leaves cout=1, ovf=1
        @(negedge clk);
        a_p = 13'hFF; b_p = 13'h00; mode_p = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;                          // accept edge
        start8 = 1'b0;
        @(posedge clk); #1;                          // RUN edge 1
        @(posedge clk); #1;                          // RUN edge 2
        rst = 1'b1;
        @(posedge clk); #1;                          // RUN edge 3 with reset
        rst = 1'b0;
        $display("mid-run reset: busy=%0b done=%0b result=%0h", busy8, done8, res8);
        chk("midrst_busy",   busy8, 0);
        chk("midrst_done",   done8, 0);
        chk("midrst_result", res8,  0);
        chk("midrst_cout",   cout8, 0);
        chk("midrst_ovf",    ovf8,  0);
        begin
            int dcnt;
            dcnt = 0;
            for (int n = 0; n < 15; n++) begin
                @(posedge clk); #1;
                if (done8) dcnt++;
            end
            chk("midrst_no_done", dcnt, 0);
        end
        run_op(8, 13'h12, 13'h34, 1'b0, r, co, ov, lat, bc, da);
        chk("after_rst_result",  r,   8'h46);
        chk("after_rst_latency", lat, 8);

        // ---------------- handshake: start ignored in RUN, back-to-back ------
        @(negedge clk);
        a_p = 13'd10; b_p = 13'd20; mode_p = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;                          // accept edge
        begin
            int found;
            found = 0;
            for (int n = 1; n <= 40; n++) begin
                // keep start high with junk operands while running
                start8 = 1'b1;
                a_p = 13'($urandom_range(0, 255));
                b_p = 13'($urandom_range(0, 255));
                mode_p = n[0];
                @(posedge clk); #1;
                if (done8) begin
                    found = n;
                    break;
                end
            end
            chk("hs_latency", found, 8);
            chk("hs_result",  res8, 30);
            $display("handshake op: result=%0d at edge %0d", res8, found);
        end
        // back-to-back accept in the done cycle
        a_p = 13'd3; b_p = 13'd1; mode_p = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("b2b_busy", busy8, 1);
        chk("b2b_done_drop", done8, 0);
        begin
            int found;
            found = -1;
            for (int n = 1; n <= 40; n++) begin
                @(posedge clk); #1;
                if (done8) begin
                    found = n;
                    break;
                end
            end
            chk("b2b_latency", found, 8);
            chk("b2b_result",  res8, 2);
            chk("b2b_cout",    cout8, 0);
            $display("back-to-back op: result=%0d at edge %0d", res8, found);
        end

        // ---------------- parametrised random vs reference ----------------
        for (int wi = 0; wi < 2; wi++) begin
            int w;
            w = (wi == 0) ? 2 : 13;
            for (int t = 0; t < 16; t++) begin
                longint mask, av, bv, full, er, ec, eo, sa, sb, sr;
                logic m;
                mask = (64'd1 << w) - 1;
                av = longint'($urandom) & mask;
                bv = longint'($urandom) & mask;
                m  = 1'($urandom_range(0, 1));
                if (m == 1'b0) begin
                    full = av + bv;
                    er = full & mask;
                    ec = (full >> w) & 1;
                end else begin
                    full = av - bv;
                    er = full & mask;
                    ec = (av < bv) ? 1 : 0;
                end
                sa = (av >> (w - 1)) & 1;
                sb = (bv >> (w - 1)) & 1;
                sr = (er >> (w - 1)) & 1;
                if (m == 1'b0) eo = (sa == sb && sr != sa) ? 1 : 0;
                else           eo = (sa != sb && sr != sa) ? 1 : 0;
                run_op(w, 13'(av), 13'(bv), m, r, co, ov, lat, bc, da);
                chk($sformatf("w%0d_t%0d_result", w, t), r,   er);
                chk($sformatf("w%0d_t%0d_cout", w, t),   co,  ec);
                chk($sformatf("w%0d_t%0d_ovf", w, t),    ov,  eo);
                chk($sformatf("w%0d_t%0d_latency", w, t), lat, w);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
